// File: rtl/btn_pkg.sv
// Shared types and default constants for the button event scheduler.
// Events are packed {id, is_long}; the per-button FSM state enum lives here too.
package btn_pkg;

  localparam int NUM_BTN = 4;
  localparam int ID_W    = 2;
  localparam int EVT_W   = ID_W + 1;

  localparam int F_COUNT_DEF    = 1000;
  localparam int HIST_DEF       = 8;
  localparam int LONG_TICKS_DEF = 50000;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btn_state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            is_long;
  } btn_evt_t;

  function automatic btn_evt_t make_evt(input logic [ID_W-1:0] id, input logic is_long);
    btn_evt_t e;
    e.id      = id;
    e.is_long = is_long;
    return e;
  endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous event queue; a write while full is accepted only when a pop
// happens in the same cycle, so occupancy stays unchanged in that case.
module btn_evt_fifo
  import btn_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  btn_evt_t               wr_data_i,
  input  logic                   rd_en_i,
  output btn_evt_t               rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  btn_evt_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_pop  = rd_en_i && !empty_o;
  assign do_push = wr_en_i && (!full_o || do_pop);

  assign rd_data_o = mem_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/btn_event_scheduler.sv
// Four-button debouncer with short/long press classification, per-button
// pending requests, fixed-priority arbitration and a small event FIFO.
module btn_event_scheduler
  import btn_pkg::*;
#(
  parameter int F_COUNT    = F_COUNT_DEF,
  parameter int HIST       = HIST_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] o_level,
  output logic               o_evt_valid,
  input  logic               i_evt_ready,
  output logic [ID_W-1:0]    o_evt_id,
  output logic               o_evt_long,
  output logic               o_overflow,
  input  logic               i_ovf_clr
);

  localparam int PRE_W = $clog2(F_COUNT);
  localparam int CNT_W = $clog2(LONG_TICKS);

  logic [PRE_W-1:0]   presc_q;
  logic               tick;
  logic [HIST-1:0]    hist_q [NUM_BTN];
  logic [NUM_BTN-1:0] level_q;

  logic [NUM_BTN-1:0] pend_vec, pend_long_vec, ovw_vec, grant;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_long, any_pend;

  btn_evt_t                    head;
  logic                        fifo_full, fifo_empty, pop, drop;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  // Shared sample-tick prescaler.
  assign tick = (presc_q == PRE_W'(F_COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst)       presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + 1'b1;
  end

  // Debounce: level only moves once the whole history agrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_BTN; k++) hist_q[k] <= '0;
      level_q <= '0;
    end else begin
      for (int k = 0; k < NUM_BTN; k++) begin
        if (tick)              hist_q[k]  <= {i_btn[k], hist_q[k][HIST-1:1]};
        if (&hist_q[k])        level_q[k] <= 1'b1;
        else if (~|hist_q[k])  level_q[k] <= 1'b0;
      end
    end
  end

  assign o_level = level_q;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_state_e       state_q;
    logic [CNT_W-1:0] hold_q;
    logic             pend_q, pend_long_q;
    logic             fall, to_long, req_vld;

    assign fall    = (state_q == ST_PRESSED) && !level_q[g];
    assign to_long = (state_q == ST_PRESSED) && level_q[g] && tick
                     && (hold_q == CNT_W'(LONG_TICKS - 2));
    assign req_vld = fall || to_long;

    // The request lands in the pending register on the same edge the FSM
    // leaves PRESSED, so a fresh event reaches the FIFO one cycle later.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        hold_q  <= '0;
        pend_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (level_q[g]) begin
              state_q <= ST_PRESSED;
              hold_q  <= '0;
            end
          end
          ST_PRESSED: begin
            if (!level_q[g]) begin
              state_q <= ST_IDLE;
            end else if (tick) begin
              hold_q <= hold_q + 1'b1;
              if (to_long) state_q <= ST_LONG;
            end
          end
          ST_LONG: begin
            if (!level_q[g]) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase

        if (req_vld)       pend_q <= 1'b1;
        else if (grant[g]) pend_q <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (req_vld) pend_long_q <= to_long;
    end

    assign pend_vec[g]      = pend_q;
    assign pend_long_vec[g] = pend_long_q;
    assign ovw_vec[g]       = req_vld && pend_q && !grant[g];
  end

  // Lowest pending index wins.
  always_comb begin
    gnt_id = '0;
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      if (pend_vec[k]) gnt_id = ID_W'(k);
    end
    any_pend = |pend_vec;
    gnt_long = pend_long_vec[gnt_id];
    grant    = '0;
    if (any_pend) grant[gnt_id] = 1'b1;
  end

  assign pop  = i_evt_ready && !fifo_empty;
  assign drop = any_pend && fifo_full && !pop;

  btn_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (any_pend),
    .wr_data_i (make_evt(gnt_id, gnt_long)),
    .rd_en_i   (i_evt_ready),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  assign o_evt_valid = (fifo_cnt != '0);
  assign o_evt_id    = head.id;
  assign o_evt_long  = head.is_long;

  // A same-cycle set beats the clear.
  always_ff @(posedge clk) begin
    if (rst)                     o_overflow <= 1'b0;
    else if ((|ovw_vec) || drop) o_overflow <= 1'b1;
    else if (i_ovf_clr)          o_overflow <= 1'b0;
  end

endmodule

// File: doc/btn_event_scheduler.md
BTN_EVENT_SCHEDULER -- requirements
Module: btn_event_scheduler

Interface
REQ-001 SHALL have parameter F_COUNT, default 1000, clk cycles per sample tick (100 kHz at 100 MHz clk).
REQ-002 SHALL have parameter HIST, default 8, debounce history length in ticks.
REQ-003 SHALL have parameter LONG_TICKS, default 50000, ticks of continuous press for a long-press event.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, event queue depth (power of 2).
REQ-005 SHALL have port clk, input, 1, single system clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_btn, input, 4, raw button levels; bit k is button k.
REQ-008 SHALL have port o_level, output, 4, debounced button levels.
REQ-009 SHALL have port o_evt_valid, output, 1, FIFO head event available.
REQ-010 SHALL have port i_evt_ready, input, 1, consumer accepts head event.
REQ-011 SHALL have port o_evt_id, output, 2, button index of head event.
REQ-012 SHALL have port o_evt_long, output, 1, head event class: 1 long press, 0 short press.
REQ-013 SHALL have port o_overflow, output, 1, sticky flag, set when an event is dropped.
REQ-014 SHALL have port i_ovf_clr, input, 1, clears o_overflow.

Function
REQ-015 SHALL use one shared prescaler counting 0..F_COUNT-1, with a 1-clk tick pulse on the cycle the count equals F_COUNT-1, then wrap to 0.
REQ-016 SHALL, on each tick, shift i_btn[k] into the MSB of a per-button HIST-bit history.
REQ-017 SHALL register o_level[k] to 1 when history k is all ones, to 0 when it is all zeros, and hold it otherwise (hysteresis).
REQ-018 SHALL run a per-button FSM with states IDLE, PRESSED and LONG.
REQ-019 SHALL implement these FSM transitions:
- IDLE to PRESSED on the clk after o_level[k] rises; hold counter cleared.
- PRESSED: hold counter increments per tick.
- PRESSED to LONG when the counter reaches LONG_TICKS-1; raises long request.
- PRESSED to IDLE on level fall; raises short request.
- LONG to IDLE on level fall; raises no event.
REQ-020 SHALL size the hold counter at $clog2(LONG_TICKS) bits so that it never wraps; it saturates in LONG.
REQ-021 SHALL hold each button's request in a 1-entry pending register {long} until granted.
REQ-022 SHALL overwrite a request that arrives while one is already pending for the same button, and set o_overflow.
REQ-023 SHALL arbitrate pending requests with fixed priority (lowest index first), granting one per clk and writing {id, long} to the FIFO; ungranted requests stay pending.
REQ-024 SHALL, on a grant while the FIFO is full and no pop occurs that clk, drop the event, clear its pending bit and set o_overflow.
REQ-025 SHALL accept the write when the FIFO is full and a pop occurs in the same clk, leaving occupancy unchanged.
REQ-026 SHALL drive o_evt_valid = FIFO not empty, with o_evt_id and o_evt_long showing the head entry and remaining stable while valid and not ready.
REQ-027 SHALL pop on valid && ready.
REQ-028 SHALL wrap FIFO pointers modulo FIFO_DEPTH and use an occupancy count of $clog2(FIFO_DEPTH)+1 bits.
REQ-029 SHALL meet this latency when the FIFO is empty and nothing is contending:
- o_level changes at edge E.
- Pending is set at E+1.
- FIFO write occurs at E+2.
- o_evt_valid is high from E+2.
REQ-030 SHALL give i_ovf_clr priority below a same-cycle overflow set: set wins.

Reset
REQ-031 SHALL, while rst is high at a clk edge, clear the prescaler, all histories, o_level, hold counters, pending bits, FIFO pointers and count, and o_overflow.
REQ-032 SHALL return all FSMs to IDLE and hold o_evt_valid at 0 during reset.
REQ-033 SHALL, when rst is asserted mid-press or mid-handshake, discard all queued and pending events.
REQ-034 SHALL suppress events after reset until the histories refill: a held button yields its first PRESSED after HIST ticks.

Structure
REQ-035 SHALL take the FSM state enum, event record width (3 bits: id[1:0], long) and default parameter constants from shared package btn_pkg.
REQ-036 SHALL implement the event queue as sub-module btn_evt_fifo (sync write/read, full/empty, count), instantiated once.

Verification (F_COUNT=4, HIST=8, LONG_TICKS=20, FIFO_DEPTH=4)
REQ-037 SHALL cover a short press: hold i_btn[2]=1 for 15 ticks, then release -> exactly one event id=2, long=0, after level fall; o_overflow=0.
REQ-038 SHALL cover bounce: toggle i_btn[0] every tick for 30 ticks -> o_level[0] never changes, no event.
REQ-039 SHALL cover a long press: hold i_btn[1] for 40 ticks -> one event id=1, long=1 at hold tick 19; release yields no second event.
REQ-040 SHALL cover a simultaneous release: release buttons 3,1,0 on the same tick -> FIFO order id 0, 1, 3 on consecutive clks.
REQ-041 SHALL cover overflow: i_evt_ready=0, generate 5 short events -> 4 queued, o_overflow=1; i_ovf_clr pulse clears it; draining returns the first 4 in order.
REQ-042 SHALL cover reset mid-operation: assert rst with 3 queued events and button 2 in PRESSED -> next clk o_evt_valid=0, o_level=0; no events until fresh presses.
